memoria_principal: RTL
======================

# memoria_principal

Main-memory responder on the cache refill/writeback port. It accepts one line-granular request at a time from the cache block, waits a programmable access latency, then streams a full line out as a read burst or absorbs a full line as a write burst. It sits below the 10-bit-address, 32-bit-data cache and serves as backing store in simulation and on FPGA.

## Interface
Parameters:
- ADDR_W, 10, word-address width; shared with the cache.
- DATA_W, 32, word width.
- LINE_WORDS, 4, words per cache line; power of two, ≥2.
- LATENCY, 3, cycles from request accept to the first data beat; ≥1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- gen_reset_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  cache presents a request.
- req_ready  out  1  responder can accept a request; high only in IDLE.
- req_write  in  1  1 = writeback line, 0 = refill line.
- req_adress  in  ADDR_W  word address; low log2(LINE_WORDS) bits ignored (line-aligned).
- wr_data  in  DATA_W  writeback word.
- wr_valid  in  1  wr_data valid this cycle.
- wr_ready  out  1  responder accepts a writeback word.
- wr_done  out  1  one-cycle pulse: writeback line committed.
- rd_data  out  DATA_W  refill word, registered.
- rd_valid  out  1  rd_data valid.
- rd_last  out  1  marks the final refill beat.
- busy  out  1  request in progress (state ≠ IDLE).

## Operation
- States: IDLE, WAIT, RD_BURST, WR_BURST, WR_ACK.
- IDLE: req_ready=1. On req_valid, latch line base = req_adress with offset bits zeroed, latch req_write, load latency counter, go to WAIT.
- WAIT: count down LATENCY cycles. Then go to RD_BURST if read, WR_BURST if write.
- RD_BURST: emit LINE_WORDS beats on consecutive cycles, in offsets 0..LINE_WORDS-1. No backpressure. rd_last is high with beat LINE_WORDS-1. Return to IDLE after the last beat.
- WR_BURST: wr_ready=1. Each cycle with wr_valid writes wr_data to base+offset and increments the offset. A low wr_valid stalls with no timeout. After offset LINE_WORDS-1 is written, go to WR_ACK.
- WR_ACK: wr_done=1 for one cycle, then return to IDLE.
- Address arithmetic: offset counter is log2(LINE_WORDS) bits and never carries into the line bits. The top line (base 0x3FC at defaults) is legal and does not wrap.
- Memory contents: not reset and undefined until written. Reset never clears the array.
- Requests arriving while busy are not accepted (req_ready=0). The cache holds req_valid until accepted.
- wr_valid outside WR_BURST is ignored.

## Timing
- Reset, sampled on a rising edge with gen_reset_n=0: state=IDLE, counters=0.
- Output values during and after reset: req_ready=1 once released, wr_ready=0, wr_done=0, rd_valid=0, rd_last=0, rd_data=0, busy=0.
- Request accepted at edge k. First rd_valid is high in the cycle after edge k+LATENCY. The last read beat follows LINE_WORDS-1 cycles later.
- Read-burst address is presented to the RAM one cycle before its beat. The synchronous-read RAM latency is hidden inside the WAIT count, so the first beat timing above holds exactly.
- Writeback: wr_ready rises in the cycle after edge k+LATENCY. wr_done pulses in the cycle after the last accepted word.
- Next request: earliest acceptance is the cycle after rd_last or wr_done. There are no back-to-back overlapping requests.
- Reset mid-burst: abort immediately. A partially written line keeps the words already written. No wr_done or rd_last is emitted for the aborted request.
- Read of a line written by the previous request returns the new data; there are no bypass hazards because requests are serialized.

## Structure
- Package memoria_pkg:
  - state enum (IDLE, WAIT, RD_BURST, WR_BURST, WR_ACK);
  - localparams OFF_W = $clog2(LINE_WORDS) and CNT_W = $clog2(LATENCY+1);
  - default ADDR_W, DATA_W and LINE_WORDS, shared with the cache block.
- Sub-module memoria_array: single-port RAM of 2^ADDR_W × DATA_W, synchronous write and registered read. It is inferred as block RAM.
- Top level: FSM, latency counter, offset counter, output registers.

## Test plan
- Reset: hold gen_reset_n=0 for 2 cycles, then release -> all outputs at reset values, req_ready=1, busy=0.
- Writeback then refill: write line base 0x010 with words 15,16,17,18, then read 0x013 -> wr_done pulses once. The refill returns 15,16,17,18 starting exactly LATENCY+1 cycles after accept, with rd_last on 18.
- Write stall: during a writeback to 0x02C, drop wr_valid for 3 cycles after word 1 (data 25,26,27,28) -> the burst extends 3 cycles and readback returns 25,26,27,28.
- Busy rejection: assert a read to 0x040 while a write to 0x020 is in WAIT -> req_ready=0. The read is accepted the cycle after wr_done and returns the 0x040 data.
- Top line: writeback to 0x3FF with 100,101,102,103, then refill -> words stored at 0x3FC..0x3FF, no wrap to 0x000, which is checked unchanged.
- Reset mid-read: assert gen_reset_n=0 on the 2nd read beat -> rd_valid=0 the next cycle, no rd_last, and the next request is accepted normally.

Source files
------------

// File: rtl/memoria_pkg.sv
// Shared definitions for the main-memory responder and the cache that sits above it.
package memoria_pkg;

  // Default geometry shared with the cache block
  localparam int MEM_ADDR_W     = 10;
  localparam int MEM_DATA_W     = 32;
  localparam int MEM_LINE_WORDS = 4;
  localparam int MEM_LATENCY    = 3;

  // Derived widths at the default geometry
  localparam int OFF_W = $clog2(MEM_LINE_WORDS);
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  // Responder FSM states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT     = 3'd1,
    RD_BURST = 3'd2,
    WR_BURST = 3'd3,
    WR_ACK   = 3'd4
  } state_e;

endpackage

// File: rtl/memoria_principal_array.sv
// Single-port RAM, synchronous write, registered read. Contents are never reset;
// only the read register is cleared so the refill bus idles at zero.
module memoria_array #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [0:(2**AW)-1];
  logic [DW-1:0] rdata_q;

  // Storage write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Read register: holds a word only in the cycle after a read, zero otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[addr];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/memoria_principal.sv
// Main-memory responder: one line request at a time, fixed access latency,
// then a full-line read burst or a full-line write burst.
module memoria_principal
  import memoria_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int LINE_WORDS = MEM_LINE_WORDS,
  parameter int LATENCY    = MEM_LATENCY
) (
  input  logic              clk,
  input  logic              gen_reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_adress,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              wr_done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              busy
);

  localparam int OFF_N = $clog2(LINE_WORDS);
  localparam int CNT_N = $clog2(LATENCY + 1);
  localparam logic [OFF_N-1:0] OFF_LAST = OFF_N'(LINE_WORDS - 1);
  localparam logic [OFF_N-1:0] OFF_ONE  = OFF_N'(1);
  localparam logic [CNT_N-1:0] CNT_LOAD = CNT_N'(LATENCY);
  localparam logic [CNT_N-1:0] CNT_ONE  = CNT_N'(1);

  state_e                    state_q, state_d;
  logic [CNT_N-1:0]          cnt_q, cnt_d;
  logic [OFF_N-1:0]          off_q, off_d;
  logic [ADDR_W-OFF_N-1:0]   line_q, line_d;
  logic                      write_q, write_d;
  logic                      req_ready_q, req_ready_d;
  logic                      wr_ready_q, wr_ready_d;
  logic                      wr_done_q, wr_done_d;
  logic                      rd_valid_q, rd_valid_d;
  logic                      rd_last_q, rd_last_d;
  logic                      busy_q, busy_d;
  logic                      ram_we_s, ram_re_s;
  logic [OFF_N-1:0]          ram_off_s;
  logic [DATA_W-1:0]         ram_rdata_s;

  // Next-state, counters and RAM control. A read beat is issued to the RAM
  // one edge before it appears, so the RAM latency hides inside the WAIT count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    off_d     = off_q;
    line_d    = line_q;
    write_d   = write_q;
    ram_we_s  = 1'b0;
    ram_re_s  = 1'b0;
    ram_off_s = off_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          line_d  = req_adress[ADDR_W-1:OFF_N];
          write_d = req_write;
          cnt_d   = CNT_LOAD;
          off_d   = '0;
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_ONE) begin
          cnt_d = '0;
          if (write_q) begin
            state_d = WR_BURST;
          end else begin
            state_d    = RD_BURST;
            ram_re_s   = 1'b1;
            ram_off_s  = '0;
            rd_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RD_BURST: begin
        // off_q is the beat currently on rd_data
        if (off_q == OFF_LAST) begin
          off_d   = '0;
          state_d = IDLE;
        end else begin
          ram_re_s   = 1'b1;
          ram_off_s  = off_q + OFF_ONE;
          off_d      = off_q + OFF_ONE;
          rd_valid_d = 1'b1;
          rd_last_d  = ((off_q + OFF_ONE) == OFF_LAST);
        end
      end
      WR_BURST: begin
        if (wr_valid) begin
          ram_we_s = 1'b1;
          if (off_q == OFF_LAST) begin
            off_d   = '0;
            state_d = WR_ACK;
          end else begin
            off_d = off_q + OFF_ONE;
          end
        end else begin
          off_d = off_q;
        end
      end
      WR_ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    wr_ready_d  = (state_d == WR_BURST);
    wr_done_d   = (state_d == WR_ACK);
  end

  // State, counters and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!gen_reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      off_q       <= '0;
      line_q      <= '0;
      write_q     <= 1'b0;
      req_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      wr_done_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      line_q      <= line_d;
      write_q     <= write_d;
      req_ready_q <= req_ready_d;
      wr_ready_q  <= wr_ready_d;
      wr_done_q   <= wr_done_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      busy_q      <= busy_d;
    end
  end

  // Offset is concatenated onto the line, so it can never carry into line bits.
  // Writes are blocked on the reset edge so an aborted burst stops at once.
  memoria_array #(
    .AW (ADDR_W),
    .DW (DATA_W)
  ) u_array (
    .clk   (clk),
    .rst_n (gen_reset_n),
    .we    (ram_we_s & gen_reset_n),
    .re    (ram_re_s),
    .addr  ({line_q, ram_off_s}),
    .wdata (wr_data),
    .rdata (ram_rdata_s)
  );

  assign req_ready = req_ready_q;
  assign wr_ready  = wr_ready_q;
  assign wr_done   = wr_done_q;
  assign rd_data   = ram_rdata_s;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign busy      = busy_q;

endmodule
